// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation into a 2-entry
// fetch buffer, with redirect flush, halt/drain and a pushed-word counter.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        halted_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_fetch_cnt;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];

    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] w_fetch_cnt_nxt;
    logic [1:0]  w_count_nxt;
    logic        w_rd_ptr_nxt;
    logic        w_wr_ptr_nxt;
    logic        w_unused_rpc_lsb;

    // Redirect targets are word aligned; the low bits are intentionally dropped.
    assign w_unused_rpc_lsb = ^redirect_pc_i[1:0];

    assign w_full = (r_count == 2'(DEPTH));
    assign w_pop  = (r_count != 2'd0) && instr_ready_i;
    assign w_push = (r_state == ST_RUN) && !halt_i && !redirect_i
                    && (!w_full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_BOOT:   w_state_nxt = ST_RUN;
            ST_RUN:    if (halt_i)  w_state_nxt = ST_HALTED;
            ST_HALTED: if (!halt_i) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_BOOT;
        endcase
    end

    // Redirect overrides both push and pop: the buffer is emptied outright.
    always_comb begin
        w_fetch_pc_nxt  = r_fetch_pc;
        w_fetch_cnt_nxt = r_fetch_cnt;
        w_count_nxt     = r_count;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        if (redirect_i) begin
            w_fetch_pc_nxt = {redirect_pc_i[31:2], 2'b00};
            w_count_nxt    = 2'd0;
            w_rd_ptr_nxt   = 1'b0;
            w_wr_ptr_nxt   = 1'b0;
        end else begin
            if (w_push) begin
                w_fetch_pc_nxt  = r_fetch_pc + 32'd4;
                w_fetch_cnt_nxt = r_fetch_cnt + 32'd1;
                w_wr_ptr_nxt    = ~r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = ~r_rd_ptr;
            end
            w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_BOOT;
            r_fetch_pc  <= RESET_PC;
            r_fetch_cnt <= '0;
            r_count     <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
            r_count     <= w_count_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
            r_buf_instr[r_wr_ptr] <= imem_instr_i;
        end
    end

    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = (r_count != 2'd0);
    assign instr_o       = r_buf_instr[r_rd_ptr];
    assign instr_pc_o    = r_buf_pc[r_rd_ptr];
    assign halted_o      = (r_state == ST_HALTED) && (r_count == 2'd0);
    assign fetch_cnt_o   = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, compared each cycle against a queue-based reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer contents as a queue of {pc, instr}.
    logic [63:0] q[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_boot;
    bit          m_halted;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    assign imem_instr = rom(imem_addr);

    fetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .instr_valid_o (valid),
        .instr_ready_i (ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .halt_i        (halt),
        .halted_o      (halted),
        .fetch_cnt_o   (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("instr_pc", instr_pc, q[0][63:32]);
            chk("instr", instr, q[0][31:0]);
        end
        chk("halted", 32'(halted), 32'(m_halted && (q.size() == 0)));
        chk("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    task automatic model_update();
        bit pop;
        int sz;
        sz  = q.size();
        pop = (sz > 0) && ready;
        if (redirect) begin
            q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_boot && !m_halted && !halt && (sz < 2 || pop)) begin
                q.push_back({m_pc, rom(m_pc)});
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
        if (m_boot) m_boot = 1'b0;
        else        m_halted = halt;
    endtask

    task automatic step();
        if (rst_n) model_update();
        @(posedge clk);
        #1;
        model_check();
    endtask

    // Reset is asserted between clock edges so its effect must be asynchronous.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        q.delete();
        m_pc     = RST_PC;
        m_cnt    = '0;
        m_boot   = 1'b1;
        m_halted = 1'b0;
        @(posedge clk);
        #1;
        model_check();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] saved_cnt;
        logic [31:0] next_pc;

        // Reset release and first two fetches
        do_reset();
        ready = 1'b1;
        step();
        chk("boot_no_valid", 32'(valid), 32'd0);
        step();
        chk("first_pc", instr_pc, 32'h0);
        chk("first_instr", instr, 32'h0050_0093);
        step();
        chk("second_pc", instr_pc, 32'h4);
        chk("second_instr", instr, 32'h0010_0113);
        chk("cnt_two", fetch_cnt, 32'd2);

        // Backpressure from reset
        ready = 1'b0;
        do_reset();
        repeat (5) step();
        chk("bp_addr_hold", imem_addr, 32'h8);
        chk("bp_cnt", fetch_cnt, 32'd2);
        chk("bp_head0", instr_pc, 32'h0);
        ready = 1'b1;
        step();
        chk("bp_head4", instr_pc, 32'h4);
        step();
        chk("bp_head8", instr_pc, 32'h8);

        // Redirect while full
        ready = 1'b0;
        repeat (3) step();
        ready       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        step();
        chk("redir_flush", 32'(valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        redirect = 1'b0;
        step();
        chk("redir_valid", 32'(valid), 32'd1);
        chk("redir_pc", instr_pc, 32'h40);
        step();
        chk("redir_next", instr_pc, 32'h44);

        // Halt with two entries: drain, freeze, resume
        ready = 1'b0;
        repeat (2) step();
        halt  = 1'b1;
        ready = 1'b1;
        repeat (2) step();
        chk("halt_drained", 32'(halted), 32'd1);
        saved_cnt = fetch_cnt;
        next_pc   = imem_addr;
        repeat (3) step();
        chk("halt_cnt_frozen", fetch_cnt, saved_cnt);
        halt = 1'b0;
        repeat (2) step();
        chk("resume_pc", instr_pc, next_pc);

        // Wrap through the top of the address space
        ready       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        chk("wrap_top", instr_pc, 32'hFFFF_FFFC);
        step();
        ready = 1'b1;
        step();
        chk("wrap_zero", instr_pc, 32'h0);

        // Asynchronous reset with a full buffer
        ready = 1'b0;
        repeat (3) step();
        chk("pre_rst_valid", 32'(valid), 32'd1);
        do_reset();
        ready = 1'b1;
        repeat (2) step();
        chk("post_rst_pc", instr_pc, RST_PC);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            ready    = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           redirect_pc = $urandom;
            if ($urandom_range(0, 11) == 0) halt = ~halt;
            if ($urandom_range(0, 99) == 0) do_reset();
            else                            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, is the fetch-buffer entries; only 2 is supported.
REQ-003 The block SHALL have a port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have a port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have a port imem_addr_o, output, 32 bits, the byte address presented to the combinational instruction ROM.
REQ-006 The block SHALL have a port imem_instr_i, input, 32 bits, the ROM word for imem_addr_o, valid in the same cycle.
REQ-007 The block SHALL have a port instr_valid_o, output, 1 bit, meaning the buffer head holds a valid instruction.
REQ-008 The block SHALL have a port instr_ready_i, input, 1 bit, meaning decode accepts the head; a pop occurs when valid and ready are both high.
REQ-009 The block SHALL have a port instr_o, output, 32 bits, the instruction at the buffer head.
REQ-010 The block SHALL have a port instr_pc_o, output, 32 bits, the PC of the buffer head.
REQ-011 The block SHALL have a port redirect_i, input, 1 bit, meaning branch/jump taken: flush and refetch.
REQ-012 The block SHALL have a port redirect_pc_i, input, 32 bits, the redirect target.
REQ-013 The block SHALL have a port halt_i, input, 1 bit, a level request to stop fetching.
REQ-014 The block SHALL have a port halted_o, output, 1 bit, meaning FSM is in HALTED and the buffer is empty.
REQ-015 The block SHALL have a port fetch_cnt_o, output, 32 bits, the count of words pushed into the buffer.

Function
REQ-016 The FSM SHALL have states BOOT, RUN and HALTED, and reset SHALL enter BOOT.
REQ-017 BOOT SHALL last exactly one cycle with no push, then go to RUN.
REQ-018 RUN SHALL go to HALTED when halt_i=1 at an edge.
REQ-019 HALTED SHALL go to RUN when halt_i=0 at an edge.
REQ-020 redirect_i SHALL have priority over halt_i for the PC and flush actions in every state; the state transition itself is still taken on halt_i.
REQ-021 imem_addr_o SHALL equal the fetch_pc register in every cycle.
REQ-022 A push SHALL occur when the state is RUN, halt_i=0, redirect_i=0, and either the buffer is not full or a pop happens in the same cycle.
REQ-023 A push SHALL write {fetch_pc, imem_instr_i} at the tail, increment fetch_pc by 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), and increment fetch_cnt_o (modulo 2^32).
REQ-024 There SHALL be no bypass: a word pushed in cycle N is visible on instr_o/instr_pc_o from cycle N+1.
REQ-025 instr_valid_o SHALL be high exactly when occupancy is greater than 0; instr_o and instr_pc_o are don't-care when it is low.
REQ-026 When full with no pop, there SHALL be no push and fetch_pc SHALL hold.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged and advance order correctly.
REQ-028 A pop from a 1-entry buffer with a concurrent push SHALL present the new word the next cycle.
REQ-029 On redirect_i=1 at an edge, the block SHALL clear occupancy to 0 and set fetch_pc to {redirect_pc_i[31:2], 2'b00}, with no push that cycle.
REQ-030 Any pop in the redirect cycle SHALL be ignored, as the popped word is discarded.
REQ-031 The redirect-to-valid latency SHALL be 2 edges: redirect at edge E, push at E+1, instr_valid_o high after E+1 with instr_pc_o equal to the target.
REQ-032 In HALTED, pops SHALL continue, so the buffer drains; halted_o=1 when state==HALTED and occupancy==0.

Reset
REQ-033 Asynchronous assertion of rst_ni=0 SHALL immediately force: state BOOT, fetch_pc=RESET_PC, occupancy=0, instr_valid_o=0, halted_o=0, fetch_cnt_o=0, and buffer pointers=0.
REQ-034 This SHALL apply identically mid-operation, including during a redirect or with a full buffer.
REQ-035 Buffer data storage need not be reset.
REQ-036 Deassertion SHALL take effect at the next rising edge; the first push occurs at the second edge after deassertion, so instr_valid_o rises after edge 2 with instr_pc_o=RESET_PC.

Verification
REQ-037 Reset release with ROM 0x0:0x00500093 and 0x4:0x00100113, ready=1: instr_pc_o 0x0 then 0x4 on consecutive cycles, instr_o as loaded, fetch_cnt_o=2 after 2 pushes.
REQ-038 Backpressure: ready=0 for 5 cycles from reset: occupancy saturates at 2, imem_addr_o holds 0x8, fetch_cnt_o=2; then ready=1 yields PCs 0x0, 0x4, 0x8 in order.
REQ-039 Redirect with redirect_pc_i=0x43 while full and ready=1: both entries dropped, next valid has instr_pc_o=0x40 exactly 2 edges later, no duplicate or stale PC.
REQ-040 Halt: halt_i=1 with 2 entries, ready=1: 2 pops, then halted_o=1, fetch_cnt_o frozen; halt_i=0 -> fetching resumes at the next sequential PC.
REQ-041 Wrap: redirect to 0xFFFF_FFFC: PCs 0xFFFF_FFFC then 0x0000_0000.
REQ-042 Async reset pulse mid-stream with 2 entries: instr_valid_o drops without waiting for a clock, and the sequence restarts at RESET_PC per REQ-036.
